hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It generates the stall, write-enable and flush controls for the PC, IF_ID, ID_EX and EX_MEM stage registers. It handles four conditions in priority order: taken-branch/jump redirect, multi-cycle MUL/DIV occupancy of EX, load-use hazards, and debug halt. It also keeps saturating performance counters for stall cycles and redirects.

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: stage-register enables,
// bubbles and flushes for redirect, MUL/DIV occupancy, load-use and debug halt.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       rd_E,
    input  logic             MemRead_E,
    input  logic             md_op_E,
    input  logic             PCSrc_E,
    input  logic             halt_req,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_WAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    // First MD cycle is spent in RUN, the last (cnt==0) is an idle drain cycle.
    localparam logic [5:0]       MD_LOAD = 6'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_next;
    logic       w_load_use;
    logic       w_stall_evt;
    logic       w_redirect_evt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_redirect_count;

    assign w_load_use = MemRead_E && (rd_E != 5'd0) &&
                        ((use_rs1_D && (rs1_D == rd_E)) ||
                         (use_rs2_D && (rs2_D == rd_E)));

    always_comb begin
        PCWrite        = 1'b1;
        IF_ID_Write    = 1'b1;
        IF_ID_Flush    = 1'b0;
        ID_EX_Write    = 1'b1;
        ID_EX_Flush    = 1'b0;
        EX_MEM_Flush   = 1'b0;
        halted         = 1'b0;
        w_stall_evt    = 1'b0;
        w_redirect_evt = 1'b0;
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;

        if (!reset) begin
            unique case (r_state)
                S_RUN: begin
                    if (PCSrc_E) begin
                        IF_ID_Flush    = 1'b1;
                        ID_EX_Flush    = 1'b1;
                        w_redirect_evt = 1'b1;
                    end else if (md_op_E) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        w_stall_evt  = 1'b1;
                        w_cnt_next   = MD_LOAD;
                        w_state_next = S_MD_WAIT;
                    end else if (w_load_use) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        w_stall_evt = 1'b1;
                    end else if (halt_req) begin
                        w_state_next = S_HALT;
                    end
                end
                S_MD_WAIT: begin
                    // All other events are deliberately ignored while EX is occupied.
                    if (r_cnt != 6'd0) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        w_stall_evt  = 1'b1;
                        w_cnt_next   = r_cnt - 6'd1;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
                S_HALT: begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    halted      = 1'b1;
                    if (!halt_req) begin
                        w_state_next = S_RUN;
                    end
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_RUN;
            r_cnt            <= 6'd0;
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_stall_evt && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_redirect_evt && (r_redirect_count != CNT_MAX)) begin
                r_redirect_count <= r_redirect_count + CNT_ONE;
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MD_LATENCY 4 and 2, and a
// 4-bit counter variant) share stimulus; control outputs are packed per instance.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1_D, rs2_D, rd_E;
    logic use_rs1_D, use_rs2_D, MemRead_E, md_op_E, PCSrc_E, halt_req;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush, halted}
    logic [6:0]  c4, c2, cs;
    logic [15:0] sc4, rc4, sc2, rc2;
    logic [3:0]  scs, rcs;

    localparam logic [6:0] IDLE  = 7'b1101000;
    localparam logic [6:0] REDIR = 7'b1111100;
    localparam logic [6:0] MDST  = 7'b0000010;
    localparam logic [6:0] LU    = 7'b0001100;
    localparam logic [6:0] HLT   = 7'b0001101;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) u_d4 (
        .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_E(rd_E),
        .MemRead_E(MemRead_E), .md_op_E(md_op_E), .PCSrc_E(PCSrc_E), .halt_req(halt_req),
        .PCWrite(c4[6]), .IF_ID_Write(c4[5]), .IF_ID_Flush(c4[4]), .ID_EX_Write(c4[3]),
        .ID_EX_Flush(c4[2]), .EX_MEM_Flush(c4[1]), .halted(c4[0]),
        .stall_cycles(sc4), .redirect_count(rc4)
    );

    hazard_ctrl #(.MD_LATENCY(2), .CNT_W(16)) u_d2 (
        .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_E(rd_E),
        .MemRead_E(MemRead_E), .md_op_E(md_op_E), .PCSrc_E(PCSrc_E), .halt_req(halt_req),
        .PCWrite(c2[6]), .IF_ID_Write(c2[5]), .IF_ID_Flush(c2[4]), .ID_EX_Write(c2[3]),
        .ID_EX_Flush(c2[2]), .EX_MEM_Flush(c2[1]), .halted(c2[0]),
        .stall_cycles(sc2), .redirect_count(rc2)
    );

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_s (
        .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_E(rd_E),
        .MemRead_E(MemRead_E), .md_op_E(md_op_E), .PCSrc_E(PCSrc_E), .halt_req(halt_req),
        .PCWrite(cs[6]), .IF_ID_Write(cs[5]), .IF_ID_Flush(cs[4]), .ID_EX_Write(cs[3]),
        .ID_EX_Flush(cs[2]), .EX_MEM_Flush(cs[1]), .halted(cs[0]),
        .stall_cycles(scs), .redirect_count(rcs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
        use_rs1_D = 1'b0; use_rs2_D = 1'b0; MemRead_E = 1'b0;
        md_op_E = 1'b0; PCSrc_E = 1'b0; halt_req = 1'b0;
    endtask

    task automatic set_lu();
        rd_E = 5'd5; MemRead_E = 1'b1; rs2_D = 5'd5; use_rs2_D = 1'b1;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        md_op_E = 1'b1;
        PCSrc_E = 1'b1;
        #2;
        chk("rst_ctl", 32'(c4), 32'(IDLE));
        chk("rst_stall", 32'(sc4), 0);
        chk("rst_redir", 32'(rc4), 0);
        step();
        step();
        idle_in();
        reset = 1'b0;

        // load-use on rs2, then rd_E=0, then rs1 variant
        set_lu(); #2;
        chk("lu_ctl", 32'(c4), 32'(LU));
        step(); idle_in(); #2;
        chk("lu_cnt", 32'(sc4), 1);
        chk("lu_after", 32'(c4), 32'(IDLE));
        set_lu(); rd_E = 5'd0; rs2_D = 5'd0; #2;
        chk("lu_x0_ctl", 32'(c4), 32'(IDLE));
        step(); idle_in(); #2;
        chk("lu_x0_cnt", 32'(sc4), 1);
        rd_E = 5'd9; MemRead_E = 1'b1; rs1_D = 5'd9; use_rs1_D = 1'b1; #2;
        chk("lu_rs1_ctl", 32'(c4), 32'(LU));
        use_rs1_D = 1'b0; #1;
        chk("lu_nouse", 32'(c4), 32'(IDLE));
        step(); idle_in(); #2;
        chk("lu_nouse_cnt", 32'(sc4), 1);

        // MD op held high: LAT4 -> 3 stalls + idle; LAT2 -> stall, idle, restart
        md_op_E = 1'b1; #2;
        chk("md4_c0", 32'(c4), 32'(MDST));
        chk("md2_c0", 32'(c2), 32'(MDST));
        step(); #1;
        chk("md4_c1", 32'(c4), 32'(MDST));
        chk("md2_c1", 32'(c2), 32'(IDLE));
        PCSrc_E = 1'b1; set_lu(); halt_req = 1'b1; #1;
        chk("md4_ign", 32'(c4), 32'(MDST));
        step(); PCSrc_E = 1'b0; halt_req = 1'b0; MemRead_E = 1'b0; #1;
        chk("md4_c2", 32'(c4), 32'(MDST));
        step(); #1;
        chk("md4_c3", 32'(c4), 32'(IDLE));
        chk("md4_cnt", 32'(sc4), 4);
        md_op_E = 1'b0;
        step(); #1;
        chk("md4_run", 32'(c4), 32'(IDLE));
        chk("md4_cnt2", 32'(sc4), 4);
        chk("md4_redir", 32'(rc4), 0);

        // reset in MD_WAIT with cnt=2
        md_op_E = 1'b1;
        step(); md_op_E = 1'b0; #1;
        chk("pre_rst_ctl", 32'(c4), 32'(MDST));
        reset = 1'b1; #1;
        chk("mdrst_ctl", 32'(c4), 32'(IDLE));
        chk("mdrst_stall", 32'(sc4), 0);
        chk("mdrst_redir", 32'(rc4), 0);
        step(); reset = 1'b0; #1;
        chk("post_rst", 32'(c4), 32'(IDLE));
        set_lu(); #1;
        chk("post_rst_lu", 32'(c4), 32'(LU));
        step(); idle_in(); #1;
        chk("post_rst_cnt", 32'(sc4), 1);

        // simultaneous: redirect wins over everything
        set_lu(); md_op_E = 1'b1; halt_req = 1'b1; PCSrc_E = 1'b1; #1;
        chk("sim_ctl", 32'(c4), 32'(REDIR));
        step(); idle_in(); #1;
        chk("sim_redir", 32'(rc4), 1);
        chk("sim_stall", 32'(sc4), 1);
        chk("sim_run", 32'(c4), 32'(IDLE));

        // halt: 5 cycles of halt_req, PCSrc pulse ignored
        halt_req = 1'b1; #1;
        chk("h_c0", 32'(c4), 32'(IDLE));
        for (int i = 1; i <= 4; i++) begin
            step();
            PCSrc_E = (i == 2);
            #1;
            chk($sformatf("h_c%0d", i), 32'(c4), 32'(HLT));
        end
        step(); halt_req = 1'b0; PCSrc_E = 1'b0; #1;
        chk("h_c5", 32'(c4), 32'(HLT));
        step(); #1;
        chk("h_exit", 32'(c4), 32'(IDLE));
        chk("h_redir", 32'(rc4), 1);

        // saturation on the 4-bit instance
        reset = 1'b1; #1; step(); reset = 1'b0;
        set_lu();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 16 || i == 20) begin
                chk($sformatf("sat_%0d", i), 32'(scs), (i < 15) ? i : 15);
            end
        end
        chk("nosat_16b", 32'(sc4), 20);
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
